// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous word-wide SRAM between instruction
// fetch (port 0) and load/store (port 1). It handles RISC-V sub-word loads
// and stores. sb/sh use read-modify-write.
//
// state | meaning
// IDLE  | arbitrate; latch winner operands
// RD    | SRAM read issued
// RESP  | read data returned to the granted port (ack)
// MERGE | read word merged with store byte/halfword
// WR    | SRAM write issued; ack1
// ERR   | rejected port-1 request; ack1 + err1, no SRAM access
module dmem_arbiter #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [AW+1:0] addr0,
  output logic          ack0,
  output logic [31:0]   rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [2:0]    funct3_1,
  input  logic [AW+1:0] addr1,
  input  logic [31:0]   wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [31:0]   rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_RESP  = 3'd2,
    S_MERGE = 3'd3,
    S_WR    = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          port_q, port_d;
  logic          we_q, we_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          grant0, grant1, bad1;
  logic [1:0]    off;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_fmt;
  logic [31:0]   merged;

  // Round-robin: port 1 wins a tie only if port 0 was granted last.
  always_comb begin
    grant1 = req1 && (!req0 || (last_grant_q == 1'b0));
    grant0 = req0 && !grant1;
    bad1   = 1'b0;
    if (!(funct3_1 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) bad1 = 1'b1;
    if (we1 && (funct3_1 > 3'd2)) bad1 = 1'b1;
    if (((funct3_1 == 3'd1) || (funct3_1 == 3'd5)) && addr1[0]) bad1 = 1'b1;
    if ((funct3_1 == 3'd2) && (addr1[1:0] != 2'b00)) bad1 = 1'b1;
  end

  // Load lane selection/extension and store lane merge from the SRAM word.
  always_comb begin
    off     = addr_q[1:0];
    ld_byte = mem_rdata[{off, 3'b000} +: 8];
    ld_half = mem_rdata[{off[1], 4'b0000} +: 16];
    case (funct3_q)
      3'd0:    ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_fmt = {24'd0, ld_byte};
      3'd5:    ld_fmt = {16'd0, ld_half};
      default: ld_fmt = mem_rdata;
    endcase
    merged = mem_rdata;
    if (funct3_q == 3'd0) merged[{off, 3'b000} +: 8] = wdata_q[7:0];
    else                  merged[{off[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // Next-state and operand latching.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant0) begin
          last_grant_d = 1'b0;
          port_d       = 1'b0;
          we_d         = 1'b0;
          funct3_d     = 3'd2;
          addr_d       = addr0;
          state_d      = S_RD;
        end else if (grant1) begin
          last_grant_d = 1'b1;
          port_d       = 1'b1;
          we_d         = we1;
          funct3_d     = funct3_1;
          addr_d       = addr1;
          wdata_d      = wdata1;
          if (bad1)                  state_d = S_ERR;
          else if (!we1)             state_d = S_RD;
          else if (funct3_1 == 3'd2) state_d = S_WR;
          else                       state_d = S_RD;
        end
      end
      S_RD:    state_d = we_q ? S_MERGE : S_RESP;
      S_MERGE: begin
        wdata_d = merged;
        state_d = S_WR;
      end
      S_RESP:  state_d = S_IDLE;
      S_WR:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Outputs decoded from state so reset kills a pending write at once.
  always_comb begin
    mem_en    = (state_q == S_RD) || (state_q == S_WR);
    mem_we    = (state_q == S_WR);
    mem_addr  = addr_q[AW+1:2];
    mem_wdata = wdata_q;
    ack0      = (state_q == S_RESP) && !port_q;
    ack1      = ((state_q == S_RESP) && port_q) || (state_q == S_WR) || (state_q == S_ERR);
    err1      = (state_q == S_ERR);
    rdata0    = ack0 ? mem_rdata : 32'd0;
    rdata1    = ((state_q == S_RESP) && port_q) ? ld_fmt : 32'd0;
    busy      = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous SRAM.
module tb_dmem_arbiter;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0;
  logic [AW+1:0] addr0;
  logic          ack0;
  logic [31:0]   rdata0;
  logic          req1;
  logic          we1;
  logic [2:0]    funct3_1;
  logic [AW+1:0] addr1;
  logic [31:0]   wdata1;
  logic          ack1;
  logic          err1;
  logic [31:0]   rdata1;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;

  logic [31:0]   mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .funct3_1(funct3_1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [2:0]  f3;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic run_txn(input vec_t v, input int idx);
    int ack_c = 0;
    int en_c = 0;
    logic got_err = 1'b0;
    logic [31:0] got_rd = 32'd0;
    if (!v.port) begin
      req0 = 1'b1; addr0 = v.addr;
    end else begin
      req1 = 1'b1; we1 = v.we; funct3_1 = v.f3; addr1 = v.addr; wdata1 = v.wdata;
    end
    for (int c = 1; c <= 8 && ack_c == 0; c++) begin
      @(negedge clk);
      if (mem_en && en_c == 0) en_c = c;
      if ((!v.port && ack0) || (v.port && ack1)) begin
        ack_c  = c;
        got_err = err1;
        got_rd = v.port ? rdata1 : rdata0;
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check($sformatf("v%0d ack_cycle", idx), ack_c, v.exp_cyc);
    check($sformatf("v%0d err1", idx), {31'd0, got_err}, {31'd0, v.exp_err});
    check($sformatf("v%0d mem_en_cycle", idx), en_c, v.exp_err ? 0 : 2);
    if (!v.we && !v.exp_err) check($sformatf("v%0d rdata", idx), got_rd, v.exp_rd);
    @(posedge clk); #1;
  endtask

  vec_t vecs[$];
  int   ack_cyc[$];
  int   ack_port[$];
  logic [31:0] ack_data[$];
  logic saw_bad;

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'd0;
    mem[4] = 32'h87654321;
    mem_rdata = 32'd0;
    rst_n = 1'b0; req0 = 1'b0; addr0 = '0; req1 = 1'b0; we1 = 1'b0;
    funct3_1 = 3'd0; addr1 = '0; wdata1 = 32'd0;

    //           port  we    f3    addr    wdata         cyc err   rdata
    vecs.push_back('{1'b1, 1'b0, 3'd2, 10'h10, 32'h0,        3, 1'b0, 32'h87654321});
    vecs.push_back('{1'b1, 1'b1, 3'd0, 10'h13, 32'h000000AB, 4, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'd0, 10'h13, 32'h0,        3, 1'b0, 32'hFFFFFFAB});
    vecs.push_back('{1'b1, 1'b0, 3'd4, 10'h13, 32'h0,        3, 1'b0, 32'h000000AB});
    vecs.push_back('{1'b1, 1'b0, 3'd2, 10'h10, 32'h0,        3, 1'b0, 32'hAB654321});
    vecs.push_back('{1'b1, 1'b1, 3'd1, 10'h12, 32'hFFFF1234, 4, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'd5, 10'h12, 32'h0,        3, 1'b0, 32'h00001234});
    vecs.push_back('{1'b1, 1'b0, 3'd1, 10'h10, 32'h0,        3, 1'b0, 32'h00004321});
    vecs.push_back('{1'b1, 1'b1, 3'd2, 10'h20, 32'hDEADBEEF, 2, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 10'h23, 32'h0,        3, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 1'b0, 3'd1, 10'h22, 32'h0,        3, 1'b0, 32'hFFFFDEAD});
    vecs.push_back('{1'b1, 1'b0, 3'd0, 10'h20, 32'h0,        3, 1'b0, 32'hFFFFFFEF});
    vecs.push_back('{1'b1, 1'b0, 3'd5, 10'h20, 32'h0,        3, 1'b0, 32'h0000BEEF});
    vecs.push_back('{1'b1, 1'b0, 3'd1, 10'h11, 32'h0,        2, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'd2, 10'h12, 32'h0,        2, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 3'd4, 10'h10, 32'h0,        2, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'd3, 10'h10, 32'h0,        2, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 3'd1, 10'h13, 32'h0,        2, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 3'd0, 10'h21, 32'hFFFFFF55, 4, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'd2, 10'h20, 32'h0,        3, 1'b0, 32'hDEAD55EF});

    // Reset values.
    repeat (2) @(negedge clk);
    check("reset_outputs", {26'd0, ack0, ack1, err1, mem_en, mem_we, busy}, 32'd0);
    check("reset_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    check("reset_rdata0", rdata0, 32'd0);
    check("reset_rdata1", rdata1, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i], i);
    check("mem_word4", mem[4], 32'h12344321);
    check("mem_word8", mem[8], 32'hDEAD55EF);

    // Both ports requesting continuously right after reset: 0,1,0,1.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 10'h20;
    req1 = 1'b1; we1 = 1'b0; funct3_1 = 3'd2; addr1 = 10'h10; wdata1 = 32'd0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ack0) begin ack_cyc.push_back(c); ack_port.push_back(0); ack_data.push_back(rdata0); end
      if (ack1) begin ack_cyc.push_back(c); ack_port.push_back(1); ack_data.push_back(rdata1); end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    check("rr_ack_count", ack_cyc.size(), 4);
    for (int k = 0; k < 4 && k < ack_cyc.size(); k++) begin
      check($sformatf("rr%0d_cycle", k), ack_cyc[k], 3 + 3*k);
      check($sformatf("rr%0d_port", k), ack_port[k], k % 2);
      check($sformatf("rr%0d_data", k), ack_data[k], (k % 2 == 0) ? 32'hDEAD55EF : 32'h12344321);
    end

    // Reset during MERGE of sb @0x10 must not write or ack.
    req1 = 1'b1; we1 = 1'b1; funct3_1 = 3'd0; addr1 = 10'h10; wdata1 = 32'h000000EE;
    repeat (3) @(negedge clk);
    check("merge_busy", {31'd0, busy}, 32'd1);
    check("merge_no_we", {31'd0, mem_we}, 32'd0);
    rst_n = 1'b0; req1 = 1'b0;
    #1;
    check("rst_we_immediate", {31'd0, mem_we}, 32'd0);
    saw_bad = 1'b0;
    @(negedge clk);
    if (mem_we || ack1) saw_bad = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_we || ack1 || busy) saw_bad = 1'b1;
    end
    check("abort_no_we_ack", {31'd0, saw_bad}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_word4", mem[4], 32'h12344321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
